// File: rtl/icache_mem_array.sv
// Line, tag and valid storage for every icache way. Executes per-way cs/we/be
// commands, returns registered read data, and sweeps valid bits after reset/flush.
package icache_mem_array_pkg;
  localparam int ICACHE_L1_ASSOCIATIVITY = 4;
  localparam int ICACHE_LINE_W           = 128;
  localparam int ICACHE_DMEM_BE_W        = ICACHE_LINE_W / 8;
  localparam int ICACHE_TVMEM_BE_W       = 3;

  typedef struct packed {
    logic                        cs;
    logic                        we;
    logic [ICACHE_DMEM_BE_W-1:0] be;
  } icache_dmem_ctrl_t;

  typedef struct packed {
    logic                         cs;
    logic                         we;
    logic [ICACHE_TVMEM_BE_W-1:0] be;
  } icache_tvmem_ctrl_t;

  typedef struct packed {
    icache_dmem_ctrl_t  [ICACHE_L1_ASSOCIATIVITY-1:0] dmem_vec;
    icache_tvmem_ctrl_t [ICACHE_L1_ASSOCIATIVITY-1:0] tvmem_vec;
  } icache_mem_ctrl_t;
endpackage

module icache_mem_array
  import icache_mem_array_pkg::*;
#(
  parameter int N_WAY  = ICACHE_L1_ASSOCIATIVITY,
  parameter int N_SETS = 64,
  parameter int LINE_W = ICACHE_LINE_W,
  parameter int TAG_W  = 20,
  parameter int IDX_W  = $clog2(N_SETS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  icache_mem_ctrl_t               mem_ctrl_i,
  input  logic [IDX_W-1:0]               index_i,
  input  logic [LINE_W-1:0]              wr_line_i,
  input  logic [TAG_W-1:0]               wr_tag_i,
  input  logic                           wr_valid_i,
  output logic                           ready_o,
  output logic                           rd_vld_o,
  output logic [N_WAY-1:0][LINE_W-1:0]   rd_line_o,
  output logic [N_WAY-1:0][TAG_W-1:0]    rd_tag_o,
  output logic [N_WAY-1:0]               rd_valid_o
);

  localparam int BE_W = LINE_W / 8;
  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(N_SETS - 1);

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_sweep_cnt;
  logic             r_rd_vld;
  logic             w_active;
  logic             w_sweep;
  logic             w_tv_rd_any;

  // A flush in READY drops the command presented alongside it.
  assign w_active = (r_state == S_READY) && !flush_i;
  assign w_sweep  = (r_state == S_INIT);
  assign ready_o  = (r_state == S_READY);
  assign rd_vld_o = r_rd_vld;

  always_comb begin
    w_tv_rd_any = 1'b0;
    for (int k = 0; k < N_WAY; k++) begin
      w_tv_rd_any = w_tv_rd_any | (mem_ctrl_i.tvmem_vec[k].cs & ~mem_ctrl_i.tvmem_vec[k].we);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_INIT;
      r_sweep_cnt <= '0;
      r_rd_vld    <= 1'b0;
    end else begin
      r_rd_vld <= w_active & w_tv_rd_any;
      case (r_state)
        S_INIT: begin
          if (flush_i) begin
            r_sweep_cnt <= '0;
          end else begin
            r_sweep_cnt <= r_sweep_cnt + 1'b1;
            if (r_sweep_cnt == LAST_SET) begin
              r_state <= S_READY;
            end
          end
        end
        default: begin
          if (flush_i) begin
            r_state     <= S_INIT;
            r_sweep_cnt <= '0;
          end
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_WAY; gi++) begin : g_way
      logic [LINE_W-1:0] r_dmem [N_SETS];
      logic [TAG_W:0]    r_tvmem [N_SETS];
      logic [LINE_W-1:0] r_rd_line;
      logic [TAG_W:0]    r_rd_tv;
      logic              w_dwe;
      logic              w_dre;
      logic              w_tv_we;
      logic              w_tv_re;
      logic [IDX_W-1:0]  w_tv_addr;
      logic [TAG_W:0]    w_tv_wdata;

      assign w_dwe = w_active & mem_ctrl_i.dmem_vec[gi].cs & mem_ctrl_i.dmem_vec[gi].we;
      assign w_dre = w_active & mem_ctrl_i.dmem_vec[gi].cs & ~mem_ctrl_i.dmem_vec[gi].we;
      assign w_tv_re = w_active & mem_ctrl_i.tvmem_vec[gi].cs & ~mem_ctrl_i.tvmem_vec[gi].we;
      // The sweep owns the tag/valid write port for the whole INIT phase.
      assign w_tv_we = w_sweep | (w_active & mem_ctrl_i.tvmem_vec[gi].cs &
                                  mem_ctrl_i.tvmem_vec[gi].we & (|mem_ctrl_i.tvmem_vec[gi].be));
      assign w_tv_addr  = w_sweep ? r_sweep_cnt : index_i;
      assign w_tv_wdata = w_sweep ? '0 : {wr_valid_i, wr_tag_i};

      always_ff @(posedge clk_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (w_dwe && mem_ctrl_i.dmem_vec[gi].be[b]) begin
            r_dmem[index_i][b*8 +: 8] <= wr_line_i[b*8 +: 8];
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_rd_line <= '0;
        end else if (w_dre) begin
          r_rd_line <= r_dmem[index_i];
        end
      end

      always_ff @(posedge clk_i) begin
        if (w_tv_we) begin
          r_tvmem[w_tv_addr] <= w_tv_wdata;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_rd_tv <= '0;
        end else if (w_tv_re) begin
          r_rd_tv <= r_tvmem[index_i];
        end
      end

      assign rd_line_o[gi]  = r_rd_line;
      assign rd_tag_o[gi]   = r_rd_tv[TAG_W-1:0];
      assign rd_valid_o[gi] = r_rd_tv[TAG_W];
    end
  endgenerate

endmodule

// File: tb/tb_icache_mem_array.sv
// Scoreboard bench for icache_mem_array: a behavioural model predicts every read
// pulse and the ready phase; a negedge monitor pops and compares.
module tb_icache_mem_array;
  import icache_mem_array_pkg::*;

  localparam int NW = 4;
  localparam int NS = 64;
  localparam int LW = 128;
  localparam int TW = 20;
  localparam int IW = 6;
  localparam int BW = LW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      flush;
  icache_mem_ctrl_t          ctrl;
  logic [IW-1:0]             idx;
  logic [LW-1:0]             wline;
  logic [TW-1:0]             wtag;
  logic                      wvalid;
  logic                      ready_o;
  logic                      rd_vld_o;
  logic [NW-1:0][LW-1:0]     rd_line_o;
  logic [NW-1:0][TW-1:0]     rd_tag_o;
  logic [NW-1:0]             rd_valid_o;

  icache_mem_array #(
    .N_WAY(NW), .N_SETS(NS), .LINE_W(LW), .TAG_W(TW), .IDX_W(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .mem_ctrl_i(ctrl), .index_i(idx),
    .wr_line_i(wline), .wr_tag_i(wtag), .wr_valid_i(wvalid),
    .ready_o(ready_o), .rd_vld_o(rd_vld_o), .rd_line_o(rd_line_o),
    .rd_tag_o(rd_tag_o), .rd_valid_o(rd_valid_o)
  );

  typedef struct {
    int                  cyc;
    logic [NW*LW-1:0]    line;
    logic [NW*TW-1:0]    tag;
    logic [NW-1:0]       valid;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: storage contents, the rd_* holding registers, and phase.
  logic [LW-1:0] m_line  [NW][NS];
  logic [TW-1:0] m_tag   [NW][NS];
  logic          m_valid [NW][NS];
  logic [LW-1:0] m_rd_line [NW];
  logic [TW-1:0] m_rd_tag  [NW];
  logic [NW-1:0] m_rd_valid;
  bit            m_ready = 1'b0;
  int            m_sweep = 0;
  bit            m_live  = 1'b0;

  task automatic chk(input bit ok, input string name, input string act, input string exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s expected %s (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_edge();
    bit   any_rd;
    exp_t e;
    if (rst) begin
      m_ready = 1'b0;
      m_sweep = 0;
      m_rd_valid = '0;
      for (int k = 0; k < NW; k++) begin
        m_rd_line[k] = '0;
        m_rd_tag[k]  = '0;
      end
      m_live = 1'b1;
      return;
    end
    if (!m_ready) begin
      if (flush) begin
        m_sweep = 0;
      end else begin
        for (int k = 0; k < NW; k++) begin
          m_valid[k][m_sweep] = 1'b0;
          m_tag[k][m_sweep]   = '0;
        end
        if (m_sweep == NS - 1) begin
          m_ready = 1'b1;
          m_sweep = 0;
        end else begin
          m_sweep++;
        end
      end
      return;
    end
    if (flush) begin
      m_ready = 1'b0;
      m_sweep = 0;
      return;
    end
    any_rd = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (ctrl.dmem_vec[k].cs && !ctrl.dmem_vec[k].we) m_rd_line[k] = m_line[k][idx];
      if (ctrl.tvmem_vec[k].cs && !ctrl.tvmem_vec[k].we) begin
        m_rd_tag[k]   = m_tag[k][idx];
        m_rd_valid[k] = m_valid[k][idx];
        any_rd = 1'b1;
      end
    end
    for (int k = 0; k < NW; k++) begin
      if (ctrl.dmem_vec[k].cs && ctrl.dmem_vec[k].we) begin
        for (int b = 0; b < BW; b++) begin
          if (ctrl.dmem_vec[k].be[b]) m_line[k][idx][b*8 +: 8] = wline[b*8 +: 8];
        end
      end
      if (ctrl.tvmem_vec[k].cs && ctrl.tvmem_vec[k].we && (ctrl.tvmem_vec[k].be != '0)) begin
        m_tag[k][idx]   = wtag;
        m_valid[k][idx] = wvalid;
      end
    end
    if (any_rd) begin
      e.cyc = cyc + 1;
      for (int k = 0; k < NW; k++) begin
        e.line[k*LW +: LW] = m_rd_line[k];
        e.tag[k*TW +: TW]  = m_rd_tag[k];
      end
      e.valid = m_rd_valid;
      q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m_live) begin
      chk(ready_o === m_ready, "ready", $sformatf("%b", ready_o), $sformatf("%b", m_ready));
      if (rd_vld_o === 1'b1) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          chk(1'b0, "rd_vld_unexpected", "1", "0");
        end else begin
          e = q.pop_front();
          $display("read cyc=%0d valid=%b tag=%h", cyc, rd_valid_o, rd_tag_o);
          chk(rd_valid_o === e.valid, "rd_valid", $sformatf("%b", rd_valid_o), $sformatf("%b", e.valid));
          chk(rd_tag_o === e.tag, "rd_tag", $sformatf("%h", rd_tag_o), $sformatf("%h", e.tag));
          chk(rd_line_o === e.line, "rd_line", $sformatf("%h", rd_line_o), $sformatf("%h", e.line));
        end
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        void'(q.pop_front());
        chk(1'b0, "rd_vld_missing", $sformatf("%b", rd_vld_o), "1");
      end
    end
  end

  task automatic rd_set(input int s, input bit with_data);
    ctrl = '0;
    for (int k = 0; k < NW; k++) begin
      ctrl.tvmem_vec[k].cs = 1'b1;
      ctrl.dmem_vec[k].cs  = with_data;
    end
    idx = IW'(s);
    tick();
    ctrl = '0;
  endtask

  task automatic wr_way(input int w, input int s, input logic [LW-1:0] line,
                        input logic [BW-1:0] be, input bit do_tv,
                        input logic [TW-1:0] tag, input logic v);
    ctrl = '0;
    if (be != '0) begin
      ctrl.dmem_vec[w].cs = 1'b1;
      ctrl.dmem_vec[w].we = 1'b1;
      ctrl.dmem_vec[w].be = be;
    end
    if (do_tv) begin
      ctrl.tvmem_vec[w].cs = 1'b1;
      ctrl.tvmem_vec[w].we = 1'b1;
      ctrl.tvmem_vec[w].be = '1;
    end
    idx = IW'(s); wline = line; wtag = tag; wvalid = v;
    tick();
    ctrl = '0;
  endtask

  task automatic count_init(input string name);
    int n = 0;
    while (ready_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(n == NS, name, $sformatf("%0d cycles", n), $sformatf("%0d cycles", NS));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready_o !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(ready_o === 1'b1, "wait_ready_timeout", $sformatf("%b", ready_o), "1");
  endtask

  initial begin
    logic [LW-1:0] pat;
    rst = 1'b1; flush = 1'b0; ctrl = '0; idx = '0; wline = '0; wtag = '0; wvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    count_init("reset_init_len");

    // Freshly swept sets read back invalid; tag-only reads leave rd_line at reset value.
    rd_set(0, 1'b0);
    chk(rd_valid_o === 4'b0000, "swept_set0_valid", $sformatf("%b", rd_valid_o), "0000");
    rd_set(31, 1'b0);
    rd_set(63, 1'b0);
    chk(rd_valid_o === 4'b0000, "swept_set63_valid", $sformatf("%b", rd_valid_o), "0000");
    tick();

    for (int s = 0; s < NS; s++) begin
      ctrl = '0;
      for (int k = 0; k < NW; k++) begin
        ctrl.dmem_vec[k]  = '{cs: 1'b1, we: 1'b1, be: '1};
        ctrl.tvmem_vec[k] = '{cs: 1'b1, we: 1'b1, be: '1};
      end
      idx = IW'(s);
      wline = {$urandom, $urandom, $urandom, $urandom};
      wtag = TW'($urandom);
      wvalid = 1'($urandom);
      tick();
    end
    ctrl = '0;

    wr_way(2, 5, {4{32'hDEADBEEF}}, '1, 1'b1, 20'h12345, 1'b1);
    rd_set(5, 1'b1);
    chk(rd_line_o[2] === {4{32'hDEADBEEF}}, "fill_line", $sformatf("%h", rd_line_o[2]), "deadbeef x4");
    chk(rd_tag_o[2] === 20'h12345, "fill_tag", $sformatf("%h", rd_tag_o[2]), "12345");
    chk(rd_valid_o[2] === 1'b1, "fill_valid", $sformatf("%b", rd_valid_o[2]), "1");

    wr_way(0, 9, {BW{8'h11}}, '1, 1'b0, '0, 1'b0);
    wr_way(0, 9, {{(BW-1){8'h55}}, 8'hAA}, 16'h0001, 1'b0, '0, 1'b0);
    rd_set(9, 1'b1);
    pat = {{(BW-1){8'h11}}, 8'hAA};
    chk(rd_line_o[0] === pat, "byte_enable", $sformatf("%h", rd_line_o[0]), $sformatf("%h", pat));

    for (int k = 0; k < NW; k++) wr_way(k, 3, {4{$urandom}}, '1, 1'b1, TW'(k + 7), 1'b1);
    rd_set(3, 1'b1);
    ctrl = '0;
    for (int k = 0; k < NW; k++) ctrl.tvmem_vec[k] = '{cs: 1'b1, we: 1'b1, be: '1};
    idx = IW'(3); wtag = '0; wvalid = 1'b0;
    tick();
    rd_set(3, 1'b0);
    chk(rd_valid_o === 4'b0000, "invalid_set", $sformatf("%b", rd_valid_o), "0000");

    flush = 1'b1;
    wr_way(1, 7, {4{32'hCAFEF00D}}, '1, 1'b1, 20'hABCDE, 1'b1);
    flush = 1'b0;
    count_init("flush_init_len");
    rd_set(7, 1'b1);
    chk(rd_valid_o === 4'b0000, "flush_set7_valid", $sformatf("%b", rd_valid_o), "0000");

    for (int i = 0; i < 600; i++) begin
      ctrl = '0;
      for (int k = 0; k < NW; k++) begin
        case ($urandom_range(0, 2))
          1: ctrl.dmem_vec[k] = '{cs: 1'b1, we: 1'b0, be: BW'($urandom)};
          2: ctrl.dmem_vec[k] = '{cs: 1'b1, we: 1'b1, be: BW'($urandom)};
          default: ctrl.dmem_vec[k] = '0;
        endcase
        case ($urandom_range(0, 2))
          1: ctrl.tvmem_vec[k] = '{cs: 1'b1, we: 1'b0, be: 3'($urandom)};
          2: ctrl.tvmem_vec[k] = '{cs: 1'b1, we: 1'b1, be: 3'($urandom)};
          default: ctrl.tvmem_vec[k] = '0;
        endcase
      end
      idx = IW'($urandom_range(0, 7));
      wline = {$urandom, $urandom, $urandom, $urandom};
      wtag = TW'($urandom);
      wvalid = 1'($urandom);
      flush = ($urandom_range(0, 299) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    ctrl = '0; flush = 1'b0; rst = 1'b0;
    wait_ready();

    // Reset in the same cycle as a read must suppress its pulse.
    for (int k = 0; k < NW; k++) ctrl.tvmem_vec[k].cs = 1'b1;
    idx = '0; rst = 1'b1;
    tick();
    rst = 1'b0; ctrl = '0;
    count_init("rst_during_read_init_len");

    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < NW; k++) ctrl.tvmem_vec[k].cs = 1'b1;
    repeat (30) tick();
    ctrl = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    count_init("rst_mid_sweep_init_len");

    rd_set(0, 1'b1);
    tick(); tick();
    chk(q.size() == 0, "scoreboard_drained", $sformatf("%0d left", q.size()), "0 left");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/icache_mem_array.md
# icache_mem_array

Storage responder for the L1 instruction cache. It sits below the icache memory controller and executes the per-way physical commands (`cs`/`we`/`be` for the data memories and the tag/valid memories) carried in `icache_mem_ctrl_t`. It holds the line, tag and valid storage for every way, returns the whole addressed set one cycle after a read, and after reset or flush sweeps all sets to clear the valid bits before it accepts any command.

## Interface
- `N_WAY`, `ICACHE_L1_ASSOCIATIVITY` (4): number of ways; sets the `dmem_vec`/`tvmem_vec` length.
- `N_SETS`, 64: number of sets; power of two, at least 2.
- `LINE_W`, 128: line width in bits; multiple of 8; data `be` has `LINE_W/8` bits.
- `TAG_W`, 20: tag width in bits.
- `IDX_W`, `$clog2(N_SETS)`: set index width.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  single-cycle request to invalidate the whole cache.
- `mem_ctrl_i`  in  `icache_mem_ctrl_t`  per-way `cs`/`we`/`be` for `dmem_vec` and `tvmem_vec`.
- `index_i`  in  `IDX_W`  set addressed by `mem_ctrl_i`.
- `wr_line_i`  in  `LINE_W`  line data for data-memory writes.
- `wr_tag_i`  in  `TAG_W`  tag for tag/valid writes.
- `wr_valid_i`  in  1  valid bit for tag/valid writes.
- `ready_o`  out  1  high when commands are accepted (state READY).
- `rd_vld_o`  out  1  one-cycle pulse: the `rd_*` outputs hold fresh read data.
- `rd_line_o`  out  `N_WAY`×`LINE_W`  registered line of each way.
- `rd_tag_o`  out  `N_WAY`×`TAG_W`  registered tag of each way.
- `rd_valid_o`  out  `N_WAY`  registered valid bit of each way.

## Operation
- FSM states:
  - INIT: after reset, or after `flush_i` in READY.
    - Each cycle, writes `valid=0` (tag=0) into every way at set `sweep_cnt`, then increments `sweep_cnt`.
    - When `sweep_cnt == N_SETS-1` has been written, goes to READY; the counter wraps to 0.
    - `ready_o=0`; `mem_ctrl_i` is ignored.
  - READY: `ready_o=1`; executes `mem_ctrl_i` every cycle.
- Command decode per way k, applied only in READY:
  - Data memory:
    - `dmem_vec[k].cs & we`: for each set bit i of `be`, write byte i of `wr_line_i` to way k, set `index_i`.
    - `cs & !we`: read way k.
  - Tag/valid memory:
    - `tvmem_vec[k].cs & we` with any `be` bit set: write `{wr_valid_i, wr_tag_i}` to way k, set `index_i`. The fields are written as a whole.
    - `cs & !we`: read way k.
- Read results:
  - Loaded into `rd_*` for the ways that were read.
  - Ways not read keep their previous `rd_*` value.
- `rd_vld_o` is asserted the cycle after any way had `tvmem_vec[k].cs & !we`.
- Reads and writes to different ways in the same cycle are both performed.
- A read never sees a same-cycle write (a way cannot be both). A read in cycle N+1 returns data written in cycle N.
- `flush_i` in READY: the same-cycle `mem_ctrl_i` is dropped, and the FSM enters INIT with `sweep_cnt=0`.
- `flush_i` during INIT restarts the sweep at 0.
- Data and tag storage is not reset; only the valid bits are made meaningful, by the sweep.

## Timing
- Values on `rst_i`, taking effect the next cycle:
  - state=INIT, `sweep_cnt=0`
  - `ready_o=0`, `rd_vld_o=0`
  - `rd_line_o=0`, `rd_tag_o=0`, `rd_valid_o=0`
- Reset asserted mid-sweep or mid-read behaves the same: the sweep restarts and any pending `rd_vld_o` is cancelled.
- INIT lasts exactly `N_SETS` cycles. `ready_o` rises on the cycle after the last sweep write; first command accepted at cycle `N_SETS` after reset deassertion.
- Read latency is 1 cycle: command in cycle N, `rd_*` and `rd_vld_o` valid in cycle N+1.
- Write latency is 1 cycle: storage is updated at the edge ending cycle N.
- Throughput is one command per cycle, with no back-pressure in READY.
- `rd_vld_o` is high for exactly one cycle per read command. Back-to-back reads give consecutive pulses.
- The upstream controller must hold off while `ready_o=0`. Commands given then are lost and raise no error.

## Test plan
- Reset sweep, `N_SETS=64`:
  - Release `rst_i` -> `ready_o=0` for cycles 0..63, `ready_o=1` at cycle 64.
  - Then a ReadSet on sets 0, 31 and 63 -> `rd_valid_o=4'b0000`, `rd_vld_o` a single pulse at N+1.
- Fill and read back:
  - WriteLineAndTag way 2, set 5, line `0xDEAD...BEEF`, tag `0x12345`, valid 1.
  - Next cycle ReadSet set 5 -> `rd_line_o[2]=0xDEAD...BEEF`, `rd_tag_o[2]=0x12345`, `rd_valid_o=4'b0100`.
- Byte enables:
  - Write way 0, set 9, `be=16'h0001`, data `0xAA` over a line of all `0x11`.
  - Read set 9 -> byte 0 = `0xAA`, other bytes `0x11`.
- InvalidSet:
  - After filling all 4 ways of set 3, InvalidSet set 3 with `wr_valid_i=0`.
  - Read set 3 -> `rd_valid_o=0`; `rd_line_o` unchanged.
- Flush with concurrent write:
  - `flush_i` in the same cycle as a write to set 7 -> the write is dropped, `ready_o=0` for 64 cycles.
  - Then read set 7 -> all ways invalid.
- Reset mid-sweep:
  - Assert `rst_i` at sweep cycle 30 -> the sweep restarts.
  - `ready_o` rises 64 cycles after `rst_i` is deasserted; `rd_vld_o` stays 0 throughout.
